// File: rtl/package_settings.sv
// package_settings: data-path widths shared across the filter chain.
package package_settings;

    // Width of the shaped filter output sample (signed two's complement).
    localparam int SIZE_FILTER_DATA = 16;

endpackage : package_settings

// File: rtl/v8_parameters.sv
// v8_parameters: FSM state encoding and default parameter values for
// v8_peak_detector.
package v8_parameters;

    // Pulse detection states.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ABOVE   = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    localparam int DEF_THRESHOLD  = 100;
    localparam int DEF_HOLDOFF    = 4;
    localparam int DEF_MAX_WIDTH  = 16;
    localparam int DEF_TIME_WIDTH = 32;

endpackage : v8_parameters

// File: rtl/v8_peak_detector.sv
// v8_peak_detector: finds the maximum sample of each over-threshold pulse,
// timestamps it, and presents it through a one-deep valid/ready slot.
// Events that complete while the slot is occupied are dropped and counted.
// Optional feature: define V8_PILEUP_REJECT_EN to discard pulses that stay
// above threshold for more than MAX_WIDTH samples (counted in rejected_count).
module v8_peak_detector
    import package_settings::*;
    import v8_parameters::*;
#(
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int HOLDOFF    = DEF_HOLDOFF,
    parameter int MAX_WIDTH  = DEF_MAX_WIDTH,
    parameter int TIME_WIDTH = DEF_TIME_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [SIZE_FILTER_DATA-1:0] input_data,
    output logic signed [SIZE_FILTER_DATA-1:0] peak_amplitude,
    output logic        [TIME_WIDTH-1:0]       peak_time,
    output logic                               peak_valid,
    input  logic                               peak_ready,
    output logic        [15:0]                 dropped_count,
    output logic        [15:0]                 rejected_count
);

    localparam logic signed [SIZE_FILTER_DATA-1:0] THRESH_VAL = SIZE_FILTER_DATA'(THRESHOLD);
    // Holdoff counter is loaded with HOLDOFF and counts down to 1; HOLDOFF of
    // 0 or 1 both give a single ignored cycle before IDLE.
    localparam int                  HOLD_W    = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(HOLDOFF);
    localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);

    if (HOLDOFF < 0 || MAX_WIDTH < 1) begin : g_param_check
        $error("v8_peak_detector: HOLDOFF must be >= 0 and MAX_WIDTH >= 1");
    end

    state_t                               state;
    logic        [TIME_WIDTH-1:0]         timestamp;
    logic signed [SIZE_FILTER_DATA-1:0]   max_value;
    logic        [TIME_WIDTH-1:0]         max_time;
    logic        [HOLD_W-1:0]             hold_cnt;

    logic over_thr;
    logic above_max;
    logic event_done;
    logic event_reject;
    logic event_accept;

    assign over_thr     = input_data > THRESH_VAL;
    assign above_max    = input_data > max_value;
    // A pulse completes on the first sub-threshold sample seen in ABOVE.
    assign event_done   = (state == S_ABOVE) && !over_thr;
    assign event_accept = event_done && !event_reject;

    // Free-running timestamp; wraps naturally from all-ones to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timestamp <= '0;
        end else begin
            timestamp <= timestamp + TIME_WIDTH'(1);
        end
    end

    // Detection FSM: track pulse maximum (earliest time wins on ties), then hold off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            max_value <= '0;
            max_time  <= '0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (over_thr) begin
                        state     <= S_ABOVE;
                        max_value <= input_data;
                        max_time  <= timestamp;
                    end
                end
                S_ABOVE: begin
                    if (!over_thr) begin
                        state    <= S_HOLDOFF;
                        hold_cnt <= HOLD_LOAD;
                    end else if (above_max) begin
                        max_value <= input_data;
                        max_time  <= timestamp;
                    end
                end
                S_HOLDOFF: begin
                    if (hold_cnt <= HOLD_ONE) begin
                        state <= S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef V8_PILEUP_REJECT_EN
    // Counter saturates one past MAX_WIDTH, which is enough to flag pile-up.
    localparam int                 WIDTH_W     = $clog2(MAX_WIDTH + 2);
    localparam logic [WIDTH_W-1:0] WIDTH_LIMIT = WIDTH_W'(MAX_WIDTH);

    logic [WIDTH_W-1:0] width_cnt;
    logic [15:0]        rejected_reg;

    // Count over-threshold samples of the current pulse, including the first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            width_cnt <= '0;
        end else if (state == S_IDLE && over_thr) begin
            width_cnt <= WIDTH_W'(1);
        end else if (state == S_ABOVE && over_thr && width_cnt <= WIDTH_LIMIT) begin
            width_cnt <= width_cnt + WIDTH_W'(1);
        end
    end

    assign event_reject = event_done && (width_cnt > WIDTH_LIMIT);

    // Saturating count of pulses discarded as pile-up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rejected_reg <= '0;
        end else if (event_reject && rejected_reg != 16'hFFFF) begin
            rejected_reg <= rejected_reg + 16'd1;
        end
    end

    assign rejected_count = rejected_reg;
`else
    assign event_reject   = 1'b0;
    assign rejected_count = 16'd0;
`endif

    // Output slot: load on completion when free or draining this edge, else drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_amplitude <= '0;
            peak_time      <= '0;
            peak_valid     <= 1'b0;
            dropped_count  <= '0;
        end else begin
            if (event_accept && (!peak_valid || peak_ready)) begin
                peak_amplitude <= max_value;
                peak_time      <= max_time;
                peak_valid     <= 1'b1;
            end else if (peak_valid && peak_ready) begin
                peak_valid <= 1'b0;
            end
            if (event_accept && peak_valid && !peak_ready && dropped_count != 16'hFFFF) begin
                dropped_count <= dropped_count + 16'd1;
            end
        end
    end

endmodule : v8_peak_detector

// File: tb/tb_v8_peak_detector.sv
// tb_v8_peak_detector: directed scenarios plus randomized pulse trains,
// checked every cycle against a pulse-level reference model.
`timescale 1ns/1ps
module tb_v8_peak_detector;
    import package_settings::*;

    localparam int THRESH = 100;
    localparam int HOLD   = 4;
    localparam int MAXW   = 16;
    localparam int TW     = 32;

    logic                               clk = 1'b0;
    logic                               reset = 1'b1;
    logic signed [SIZE_FILTER_DATA-1:0] input_data = '0;
    logic signed [SIZE_FILTER_DATA-1:0] peak_amplitude;
    logic        [TW-1:0]               peak_time;
    logic                               peak_valid;
    logic                               peak_ready = 1'b1;
    logic        [15:0]                 dropped_count;
    logic        [15:0]                 rejected_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: edge index since reset, first edge that may
    // detect again, current pulse summary, and the one-deep output slot.
    int     cyc;
    int     dead_until;
    bit     in_pulse;
    int     pmax;
    longint ptime;
    int     pwidth;
    bit     m_valid;
    int     m_amp;
    longint m_time;
    int     m_drop;
    int     m_rej;

    v8_peak_detector #(
        .THRESHOLD (THRESH),
        .HOLDOFF   (HOLD),
        .MAX_WIDTH (MAXW),
        .TIME_WIDTH(TW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .input_data    (input_data),
        .peak_amplitude(peak_amplitude),
        .peak_time     (peak_time),
        .peak_valid    (peak_valid),
        .peak_ready    (peak_ready),
        .dropped_count (dropped_count),
        .rejected_count(rejected_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        cyc        = 0;
        dead_until = 0;
        in_pulse   = 0;
        pmax       = 0;
        ptime      = 0;
        pwidth     = 0;
        m_valid    = 0;
        m_amp      = 0;
        m_time     = 0;
        m_drop     = 0;
        m_rej      = 0;
    endtask

    // One clock edge of the reference: sample s, consumer ready r.
    task automatic model_step(input int s, input bit r);
        bit done;
        bit pileup;
        done   = 0;
        pileup = 0;
        if (cyc < dead_until) begin
            // inside the dead window after a pulse: input ignored
        end else if (!in_pulse) begin
            if (s > THRESH) begin
                in_pulse = 1;
                pmax     = s;
                ptime    = cyc;
                pwidth   = 1;
            end
        end else if (s > THRESH) begin
            pwidth++;
            if (s > pmax) begin
                pmax  = s;
                ptime = cyc;
            end
        end else begin
            in_pulse   = 0;
            done       = 1;
            dead_until = cyc + 1 + ((HOLD > 0) ? HOLD : 1);
        end
`ifdef V8_PILEUP_REJECT_EN
        pileup = (pwidth > MAXW);
`endif
        if (done) begin
            if (pileup) begin
                if (m_rej < 65535) m_rej++;
                if (m_valid && r) m_valid = 0;
            end else if (m_valid && !r) begin
                if (m_drop < 65535) m_drop++;
            end else begin
                m_valid = 1;
                m_amp   = pmax;
                m_time  = ptime;
            end
        end else if (m_valid && r) begin
            m_valid = 0;
        end
        cyc++;
    endtask

    // Drive one sample, advance one edge, compare everything against the model.
    task automatic run_cycle(input int s, input bit r);
        input_data = SIZE_FILTER_DATA'(s);
        peak_ready = r;
        if (peak_valid && r) begin
            $display("xfer amp=%0d time=%0d dropped=%0d rejected=%0d",
                     $signed(peak_amplitude), peak_time, dropped_count, rejected_count);
        end
        model_step(s, r);
        @(posedge clk);
        #1;
        check("valid", peak_valid, m_valid);
        if (m_valid) begin
            check("amplitude", $signed(peak_amplitude), m_amp);
            check("time", peak_time, m_time);
        end
        check("dropped", dropped_count, m_drop);
        check("rejected", rejected_count, m_rej);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        input_data = '0;
        reset      = 1'b1;
        #1;
        check("rst_valid", peak_valid, 0);
        check("rst_dropped", dropped_count, 0);
        check("rst_rejected", rejected_count, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic zeros(input int n, input bit r);
        for (int i = 0; i < n; i++) run_cycle(0, r);
    endtask

    initial begin
        int burst;
        int s;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Basic pulse: peak 300 at timestamp 12, reported after the edge sampling 90.
        zeros(10, 1'b1);
        run_cycle(0, 1'b1);
        run_cycle(150, 1'b1);
        run_cycle(300, 1'b1);
        run_cycle(250, 1'b1);
        run_cycle(90, 1'b1);
        check("basic_valid", peak_valid, 1);
        check("basic_amp", $signed(peak_amplitude), 300);
        check("basic_time", peak_time, 12);
        zeros(8, 1'b1);

        // Held event with consumer stalled; second pulse is dropped.
        do_reset();
        zeros(11, 1'b0);
        run_cycle(150, 1'b0);
        run_cycle(300, 1'b0);
        run_cycle(250, 1'b0);
        run_cycle(90, 1'b0);
        zeros(5, 1'b0);
        run_cycle(200, 1'b0);
        run_cycle(0, 1'b0);
        check("drop_count", dropped_count, 1);
        check("drop_held_amp", $signed(peak_amplitude), 300);
        run_cycle(0, 1'b1);
        check("drop_drained", peak_valid, 0);
        zeros(6, 1'b1);

        // Flat top keeps the earliest timestamp.
        do_reset();
        zeros(5, 1'b1);
        run_cycle(200, 1'b1);
        run_cycle(200, 1'b1);
        run_cycle(200, 1'b1);
        run_cycle(0, 1'b1);
        check("flat_time", peak_time, 5);
        check("flat_amp", $signed(peak_amplitude), 200);
        zeros(6, 1'b1);

        // Long pulse: pile-up rejected when enabled, reported otherwise.
        do_reset();
        zeros(3, 1'b1);
        for (int i = 0; i < 20; i++) run_cycle(150, 1'b1);
        run_cycle(0, 1'b1);
`ifdef V8_PILEUP_REJECT_EN
        check("pileup_rejected", rejected_count, 1);
        check("pileup_no_event", peak_valid, 0);
`else
        check("long_amp", $signed(peak_amplitude), 150);
        check("long_time", peak_time, 3);
        check("long_rejected", rejected_count, 0);
`endif
        zeros(6, 1'b1);

        // Reset mid-pulse discards the pulse.
        do_reset();
        zeros(2, 1'b1);
        run_cycle(200, 1'b1);
        run_cycle(300, 1'b1);
        do_reset();
        run_cycle(50, 1'b1);
        zeros(6, 1'b1);
        check("midrst_no_event", peak_valid, 0);

        // Sample during holdoff is ignored; detection resumes after 4 cycles.
        do_reset();
        zeros(2, 1'b1);
        run_cycle(150, 1'b1);
        run_cycle(50, 1'b1);
        run_cycle(0, 1'b1);
        run_cycle(101, 1'b1);
        run_cycle(0, 1'b1);
        run_cycle(0, 1'b1);
        check("holdoff_ignored", peak_valid, 0);
        run_cycle(101, 1'b1);
        run_cycle(100, 1'b1);
        check("after_holdoff_amp", $signed(peak_amplitude), 101);
        check("after_holdoff_valid", peak_valid, 1);
        zeros(6, 1'b1);

        // Randomized pulse trains with a sometimes-stalled consumer.
        do_reset();
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            if (burst > 0) begin
                s = $urandom_range(101, 400);
                burst--;
            end else if ($urandom_range(0, 7) == 0) begin
                burst = $urandom_range(1, 22);
                s     = $urandom_range(101, 400);
                burst--;
            end else begin
                s = int'($urandom_range(0, 200)) - 100;
            end
            run_cycle(s, $urandom_range(0, 3) != 0);
        end
        zeros(10, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_v8_peak_detector
